// File: rtl/q_pkg.sv
// Shared types and saturation helper for the multi-lane fixed-point add/sub/accumulate pipeline.
// FIXED_WIDTH sets the Q-format word width used by every lane.
`ifndef FIXED_WIDTH
`define FIXED_WIDTH 16
`endif

package q_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'd0,
      OP_SUB  = 2'd1,
      OP_ACC  = 2'd2,
      OP_LOAD = 2'd3
   } q_op_t;

   localparam int Q_WIDTH = `FIXED_WIDTH;
   localparam logic [Q_WIDTH-1:0] FIXED_MAX = {1'b0, {(Q_WIDTH-1){1'b1}}};
   localparam logic [Q_WIDTH-1:0] FIXED_MIN = {1'b1, {(Q_WIDTH-1){1'b0}}};

   // Clamp a one-bit-extended result back to Q_WIDTH; returns {sat, value}.
   function automatic logic [Q_WIDTH:0] q_sat(input logic signed [Q_WIDTH:0] v);
      logic [Q_WIDTH:0] r;
      if (v[Q_WIDTH] != v[Q_WIDTH-1])
         r = {1'b1, (v[Q_WIDTH] ? FIXED_MIN : FIXED_MAX)};
      else
         r = {1'b0, v[Q_WIDTH-1:0]};
      return r;
   endfunction

endpackage

// File: rtl/q_addsub_lane.sv
// One lane's stage-1 arithmetic: sign-extended add/sub/accumulate with saturation,
// plus the lane accumulator, which only changes on an accepted input beat.
module q_addsub_lane
   import q_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               acc_we,
   input  q_op_t              op,
   input  logic [Q_WIDTH-1:0] a,
   input  logic [Q_WIDTH-1:0] b,
   output logic [Q_WIDTH-1:0] result,
   output logic               sat
);

   logic [Q_WIDTH-1:0] acc_reg;
   logic [Q_WIDTH:0]   sum;
   logic [Q_WIDTH:0]   clamped;
   logic [Q_WIDTH:0]   a_ext;
   logic [Q_WIDTH:0]   b_ext;
   logic [Q_WIDTH:0]   acc_ext;

   assign a_ext   = {a[Q_WIDTH-1], a};
   assign b_ext   = {b[Q_WIDTH-1], b};
   assign acc_ext = {acc_reg[Q_WIDTH-1], acc_reg};

   // The extra bit keeps 0 - FIXED_MIN representable so it clamps instead of wrapping.
   always_comb begin
      sum = '0;
      unique case (op)
         OP_ADD:  sum = a_ext + b_ext;
         OP_SUB:  sum = a_ext - b_ext;
         OP_ACC:  sum = acc_ext + a_ext;
         OP_LOAD: sum = a_ext;
         default: sum = '0;
      endcase
   end

   assign clamped = q_sat(sum);
   assign result  = clamped[Q_WIDTH-1:0];
   assign sat     = clamped[Q_WIDTH];

   always_ff @(posedge clk) begin
      if (rst)
         acc_reg <= '0;
      else if (acc_we && (op == OP_ACC || op == OP_LOAD))
         acc_reg <= result;
   end

endmodule

// File: rtl/q_addsub_pipe.sv
// Two-stage, multi-lane saturating add/sub/accumulate unit with valid/ready on both sides.
// Stage 1 holds the saturated lane results; stage 2 is the output register.
`ifndef FIXED_WIDTH
`define FIXED_WIDTH 16
`endif

module q_addsub_pipe
   import q_pkg::*;
#(
   // Lanes are built at Q_WIDTH, so WIDTH must track FIXED_WIDTH.
   parameter int WIDTH = `FIXED_WIDTH,
   parameter int LANES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [1:0]             in_op,
   input  logic [LANES*WIDTH-1:0] in_a,
   input  logic [LANES*WIDTH-1:0] in_b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*WIDTH-1:0] out_result,
   output logic [LANES-1:0]       out_sat,
   output logic [LANES-1:0]       ovf_sticky,
   input  logic                   ovf_clr
);

   logic                   en;
   logic                   in_xfer;
   logic                   out_xfer;
   logic [LANES*WIDTH-1:0] lane_result;
   logic [LANES-1:0]       lane_sat;

   logic                   s1_valid_reg;
   logic [LANES*WIDTH-1:0] s1_result_reg;
   logic [LANES-1:0]       s1_sat_reg;
   logic                   s2_valid_reg;
   logic [LANES*WIDTH-1:0] s2_result_reg;
   logic [LANES-1:0]       s2_sat_reg;
   logic [LANES-1:0]       sticky_reg;

   // Whole pipe advances together; only a full, unaccepted output stalls it.
   assign en       = !s2_valid_reg || out_ready;
   assign in_ready = en;
   assign in_xfer  = in_valid && en;
   assign out_xfer = s2_valid_reg && out_ready;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         q_addsub_lane u_lane (
            .clk    (clk),
            .rst    (rst),
            .acc_we (in_xfer),
            .op     (q_op_t'(in_op)),
            .a      (in_a[gi*WIDTH +: WIDTH]),
            .b      (in_b[gi*WIDTH +: WIDTH]),
            .result (lane_result[gi*WIDTH +: WIDTH]),
            .sat    (lane_sat[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_reg  <= 1'b0;
         s1_result_reg <= '0;
         s1_sat_reg    <= '0;
         s2_valid_reg  <= 1'b0;
         s2_result_reg <= '0;
         s2_sat_reg    <= '0;
      end else if (en) begin
         s1_valid_reg  <= in_valid;
         s1_result_reg <= lane_result;
         s1_sat_reg    <= lane_sat;
         s2_valid_reg  <= s1_valid_reg;
         s2_result_reg <= s1_result_reg;
         s2_sat_reg    <= s1_sat_reg;
      end
   end

   // A saturating beat leaving the unit beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst)
         sticky_reg <= '0;
      else
         sticky_reg <= (ovf_clr ? '0 : sticky_reg) | (out_xfer ? s2_sat_reg : '0);
   end

   assign out_valid  = s2_valid_reg;
   assign out_result = s2_result_reg;
   assign out_sat    = s2_sat_reg;
   assign ovf_sticky = sticky_reg;

endmodule

// File: tb/tb_q_addsub_pipe.sv
// Scoreboard bench for q_addsub_pipe: a behavioural lane model pushes expected beats at
// input transfer and the output monitor pops and compares them at output transfer.
module tb_q_addsub_pipe;

   localparam int W  = 16;
   localparam int L  = 4;
   localparam int VW = W * L;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1:0]    in_op = 2'd0;
   logic [VW-1:0] in_a = '0;
   logic [VW-1:0] in_b = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [VW-1:0] out_result;
   logic [L-1:0]  out_sat;
   logic [L-1:0]  ovf_sticky;
   logic          ovf_clr = 1'b0;

   int checks = 0;
   int errors = 0;
   int n_out  = 0;

   int            model_acc [L];
   logic [VW-1:0] exp_res_q [$];
   logic [L-1:0]  exp_sat_q [$];
   logic          prev_stall = 1'b0;
   logic [VW-1:0] prev_res;
   logic [L-1:0]  prev_sat;
   logic          rand_done;

   q_addsub_pipe #(.WIDTH(W), .LANES(L)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_sat    (out_sat),
      .ovf_sticky (ovf_sticky),
      .ovf_clr    (ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Behavioural model: full-precision integer math, then clamp.
   task automatic push_expected();
      logic [VW-1:0] r;
      logic [L-1:0]  s;
      int a, b, v;
      r = '0;
      s = '0;
      for (int l = 0; l < L; l++) begin
         a = int'($signed(in_a[l*W +: W]));
         b = int'($signed(in_b[l*W +: W]));
         case (in_op)
            2'd0:    v = a + b;
            2'd1:    v = a - b;
            2'd2:    v = model_acc[l] + a;
            default: v = a;
         endcase
         if (v > 32767) begin
            v = 32767;
            s[l] = 1'b1;
         end else if (v < -32768) begin
            v = -32768;
            s[l] = 1'b1;
         end
         if (in_op >= 2'd2) model_acc[l] = v;
         r[l*W +: W] = v[W-1:0];
      end
      exp_res_q.push_back(r);
      exp_sat_q.push_back(s);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         exp_res_q.delete();
         exp_sat_q.delete();
         for (int l = 0; l < L; l++) model_acc[l] = 0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall)
            check("hold", {out_valid, out_sat, out_result}, {1'b1, prev_sat, prev_res});
         if (out_valid && out_ready) begin
            check("q_nonempty", (exp_res_q.size() != 0), 1'b1);
            if (exp_res_q.size() != 0) begin
               check("result", out_result, exp_res_q.pop_front());
               check("sat", out_sat, exp_sat_q.pop_front());
               n_out++;
               $display("beat %0d: result=%h sat=%b sticky=%b", n_out, out_result, out_sat, ovf_sticky);
            end
         end
         if (in_valid && in_ready) push_expected();
         prev_stall = out_valid && !out_ready;
         prev_res   = out_result;
         prev_sat   = out_sat;
      end
   end

   // Drive a beat and return #1 after the edge that accepted it.
   task automatic send(input logic [1:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b);
      bit done;
      done = 1'b0;
      in_valid = 1'b1;
      in_op = op;
      in_a = a;
      in_b = b;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            done = 1'b1;
         end
      end
      check("send_accept", done, 1'b1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && exp_res_q.size() != 0; i++) @(negedge clk);
      check("drain", exp_res_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic rand_beat();
      send(2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom});
   endtask

   initial begin
      int n0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_result", out_result, '0);
      check("rst_out_sat", out_sat, '0);
      check("rst_sticky", ovf_sticky, '0);
      @(posedge clk);
      #1 rst = 1'b0;

      // 1: plain add and two-cycle latency
      send(2'd0, {16'h1111, 16'h2222, 16'h7000, 16'h4000}, {16'h3333, 16'h8000, 16'h7000, 16'h2000});
      @(negedge clk);
      check("lat_cycle1", out_valid, 1'b0);
      @(negedge clk);
      check("lat_cycle2", out_valid, 1'b1);
      drain();
      check("sticky_t1", ovf_sticky, 4'b0010);

      // 2: positive saturation on add and on 0 - FIXED_MIN
      send(2'd0, {16'h0001, 16'h0001, 16'h0001, 16'h6666}, {16'h0001, 16'h0001, 16'h0001, 16'h6666});
      send(2'd1, {16'h0005, 16'h0005, 16'h0005, 16'h0000}, {16'h0002, 16'h0002, 16'h0002, 16'h8000});
      drain();
      check("sticky_t2", ovf_sticky, 4'b0011);
      ovf_clr = 1'b1;
      @(posedge clk);
      #1 ovf_clr = 1'b0;
      @(negedge clk);
      check("sticky_clr", ovf_sticky, 4'b0000);
      @(posedge clk);
      #1;

      // 3: negative saturation, negative add without saturation
      send(2'd1, {16'h0010, 16'h0020, 16'h0030, 16'h8000}, {16'h0001, 16'h0001, 16'h0001, 16'h0001});
      send(2'd0, {16'hFFF0, 16'h0100, 16'h2000, 16'hC000}, {16'h0010, 16'hFF00, 16'h1000, 16'hE000});
      drain();
      check("sticky_t3", ovf_sticky, 4'b0001);

      // 4: load then back-to-back accumulates
      send(2'd3, {16'h8000, 16'h7FFF, 16'hF000, 16'h1000}, {$urandom, $urandom});
      repeat (3) send(2'd2, {16'h8000, 16'h0001, 16'hFFFF, 16'h3000}, {$urandom, $urandom});
      drain();

      // 5: stalled output with continuous input, then a 6-beat stream
      n0 = n_out;
      fork
         begin
            out_ready = 1'b0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            check("stall_in_ready", in_ready, 1'b0);
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b1;
         end
         begin
            repeat (6) rand_beat();
         end
      join
      drain();
      check("stream_count", n_out - n0, 6);

      // random traffic with random backpressure
      rand_done = 1'b0;
      fork
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1 out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
         begin
            repeat (16) rand_beat();
            rand_done = 1'b1;
         end
      join
      drain();

      // 6: reset with two beats in flight
      send(2'd0, {$urandom, $urandom}, {$urandom, $urandom});
      send(2'd2, {$urandom, $urandom}, {$urandom, $urandom});
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_flush_valid", out_valid, 1'b0);
      check("rst_flush_sticky", ovf_sticky, 4'b0000);
      @(negedge clk);
      check("rst_flush_valid2", out_valid, 1'b0);
      @(posedge clk);
      #1;
      send(2'd2, {16'h0010, 16'h0010, 16'h0010, 16'h0010}, '0);
      drain();

      // clear coinciding with a saturating output beat: set wins
      send(2'd0, {16'h0001, 16'h0001, 16'h0001, 16'h6666}, {16'h0001, 16'h0001, 16'h0001, 16'h6666});
      @(posedge clk);
      #1 ovf_clr = 1'b1;
      @(posedge clk);
      #1 ovf_clr = 1'b0;
      @(negedge clk);
      check("sticky_set_wins", ovf_sticky, 4'b0001);
      drain();
      check("final_queue", exp_res_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
